// File: rtl/video_mnist_pkg.sv
// Shared constants and types for the MNIST colour overlay parameter sequencer.
package video_mnist_pkg;

    localparam int unsigned DEF_MODE_WIDTH   = 3;
    localparam int unsigned DEF_TCOUNT_WIDTH = 4;

    localparam logic [DEF_MODE_WIDTH-1:0] MODE_BYPASS = 3'd0;
    localparam logic [DEF_MODE_WIDTH-1:0] MODE_BINARY = 3'd1;
    localparam logic [DEF_MODE_WIDTH-1:0] MODE_DETECT = 3'd2;
    localparam logic [DEF_MODE_WIDTH-1:0] MODE_NUMBER = 3'd4;

    typedef enum logic {
        WAIT_FIRST,
        RUN
    } seq_state_e;

endpackage

// File: rtl/video_mnist_th_sweep.sv
// Per-frame threshold sweep: hold counter plus bounded wrap of the threshold step.
module video_mnist_th_sweep
    import video_mnist_pkg::*;
#(
    parameter int unsigned TCOUNT_WIDTH = DEF_TCOUNT_WIDTH,
    parameter int unsigned HOLD_WIDTH   = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    sof,
    input  logic                    enable,
    input  logic                    inhibit,
    input  logic [TCOUNT_WIDTH-1:0] th_min,
    input  logic [TCOUNT_WIDTH-1:0] th_max,
    input  logic [HOLD_WIDTH-1:0]   hold,
    input  logic [TCOUNT_WIDTH-1:0] cur_th,
    output logic                    step,
    output logic [TCOUNT_WIDTH-1:0] next_th
);

    logic [HOLD_WIDTH-1:0] hold_cnt_q;
    logic [HOLD_WIDTH-1:0] hold_cnt_d;
    logic [HOLD_WIDTH-1:0] hold_last;

    // A hold of zero behaves like a hold of one: step on every frame.
    assign hold_last = (hold == '0) ? '0 : hold - HOLD_WIDTH'(1);

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        step       = 1'b0;
        if (!enable) begin
            hold_cnt_d = '0;
        end else if (sof) begin
            if (inhibit) begin
                hold_cnt_d = '0;
            end else if (hold_cnt_q >= hold_last) begin
                // >= keeps the sweep moving if hold shrinks below the running count
                step       = 1'b1;
                hold_cnt_d = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_WIDTH'(1);
            end
        end
    end

    always_comb begin
        if ((th_min > th_max) || (cur_th >= th_max) || (cur_th < th_min)) begin
            next_th = th_min;
        end else begin
            next_th = cur_th + TCOUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/video_mnist_color_sequencer.sv
// Frame-synchronous param_mode/param_th scheduler for video_mnist_color_core.
// Optional watchdog on pending host updates: define VIDEO_MNIST_SEQ_TIMEOUT_EN.
module video_mnist_color_sequencer
    import video_mnist_pkg::*;
#(
    parameter int unsigned TUSER_WIDTH     = 1,
    parameter int unsigned TCOUNT_WIDTH    = DEF_TCOUNT_WIDTH,
    parameter int unsigned MODE_WIDTH      = DEF_MODE_WIDTH,
    parameter int unsigned FRAME_CNT_WIDTH = 16,
    parameter int unsigned HOLD_WIDTH      = 8,
    parameter logic [MODE_WIDTH-1:0] INIT_PARAM_MODE = MODE_WIDTH'(MODE_DETECT),
    parameter int unsigned INIT_PARAM_TH   = 5
`ifdef VIDEO_MNIST_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES  = 2**20
`endif
) (
    input  logic                       aresetn,
    input  logic                       aclk,
    input  logic [TUSER_WIDTH-1:0]     mon_tuser,
    input  logic                       mon_tvalid,
    input  logic                       mon_tready,
    input  logic [MODE_WIDTH-1:0]      cfg_mode,
    input  logic [TCOUNT_WIDTH-1:0]    cfg_th,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic                       sweep_enable,
    input  logic [TCOUNT_WIDTH-1:0]    sweep_th_min,
    input  logic [TCOUNT_WIDTH-1:0]    sweep_th_max,
    input  logic [HOLD_WIDTH-1:0]      sweep_hold,
    output logic [MODE_WIDTH-1:0]      param_mode,
    output logic [TCOUNT_WIDTH-1:0]    param_th,
    output logic                       param_update,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       pending
`ifdef VIDEO_MNIST_SEQ_TIMEOUT_EN
    ,
    output logic                       timeout_flag
`endif
);

    seq_state_e                 state_q, state_d;
    logic [MODE_WIDTH-1:0]      mode_q, mode_d;
    logic [TCOUNT_WIDTH-1:0]    th_q, th_d;
    logic [MODE_WIDTH-1:0]      sh_mode_q, sh_mode_d;
    logic [TCOUNT_WIDTH-1:0]    sh_th_q, sh_th_d;
    logic                       pending_q, pending_d;
    logic                       update_q, update_d;
    logic [FRAME_CNT_WIDTH-1:0] fc_q, fc_d;

    logic                       sof;
    logic                       cfg_accept;
    logic                       sweep_step;
    logic [TCOUNT_WIDTH-1:0]    sweep_next_th;

`ifdef VIDEO_MNIST_SEQ_TIMEOUT_EN
    localparam int unsigned TO_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic                flag_q, flag_d;
`endif

    assign sof        = mon_tvalid & mon_tready & mon_tuser[0];
    assign cfg_accept = cfg_valid & ~pending_q;

    video_mnist_th_sweep #(
        .TCOUNT_WIDTH (TCOUNT_WIDTH),
        .HOLD_WIDTH   (HOLD_WIDTH)
    ) u_th_sweep (
        .aclk    (aclk),
        .aresetn (aresetn),
        .sof     (sof && (state_q == RUN)),
        .enable  (sweep_enable),
        .inhibit (pending_q),
        .th_min  (sweep_th_min),
        .th_max  (sweep_th_max),
        .hold    (sweep_hold),
        .cur_th  (th_q),
        .step    (sweep_step),
        .next_th (sweep_next_th)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        th_d      = th_q;
        sh_mode_d = sh_mode_q;
        sh_th_d   = sh_th_q;
        pending_d = pending_q;
        update_d  = 1'b0;
        fc_d      = fc_q;
`ifdef VIDEO_MNIST_SEQ_TIMEOUT_EN
        to_cnt_d  = '0;
        flag_d    = flag_q;
`endif

        if (sof) begin
            fc_d = fc_q + FRAME_CNT_WIDTH'(1);
        end

        case (state_q)
            WAIT_FIRST: begin
                // No frame in flight yet, so host requests take effect straight away.
                if (cfg_accept) begin
                    mode_d   = cfg_mode;
                    th_d     = cfg_th;
                    update_d = 1'b1;
                end
                if (sof) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cfg_accept) begin
                    sh_mode_d = cfg_mode;
                    sh_th_d   = cfg_th;
                    pending_d = 1'b1;
                end
                if (sof && pending_q) begin
                    mode_d    = sh_mode_q;
                    th_d      = sh_th_q;
                    pending_d = 1'b0;
                    update_d  = 1'b1;
                end else if (sweep_step) begin
                    th_d     = sweep_next_th;
                    update_d = 1'b1;
                end
`ifdef VIDEO_MNIST_SEQ_TIMEOUT_EN
                else if (pending_q && (to_cnt_q == TO_LIMIT)) begin
                    mode_d    = sh_mode_q;
                    th_d      = sh_th_q;
                    pending_d = 1'b0;
                    update_d  = 1'b1;
                    flag_d    = 1'b1;
                end else if (pending_q && !sof) begin
                    to_cnt_d = to_cnt_q + TO_CNT_W'(1);
                end
`endif
            end
            default: state_d = WAIT_FIRST;
        endcase

`ifdef VIDEO_MNIST_SEQ_TIMEOUT_EN
        if (cfg_accept) begin
            flag_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= WAIT_FIRST;
            mode_q    <= INIT_PARAM_MODE;
            th_q      <= TCOUNT_WIDTH'(INIT_PARAM_TH);
            sh_mode_q <= '0;
            sh_th_q   <= '0;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            th_q      <= th_d;
            sh_mode_q <= sh_mode_d;
            sh_th_q   <= sh_th_d;
            pending_q <= pending_d;
            update_q  <= update_d;
            fc_q      <= fc_d;
        end
    end

`ifdef VIDEO_MNIST_SEQ_TIMEOUT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            to_cnt_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            flag_q   <= flag_d;
        end
    end

    assign timeout_flag = flag_q;
`endif

    assign cfg_ready    = ~pending_q;
    assign param_mode   = mode_q;
    assign param_th     = th_q;
    assign param_update = update_q;
    assign frame_count  = fc_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_video_mnist_color_sequencer.sv
// Bench for video_mnist_color_sequencer: directed scenarios plus random traffic vs a frame model.
module tb_video_mnist_color_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [0:0]  mon_tuser;
    logic        mon_tvalid;
    logic        mon_tready;
    logic [2:0]  cfg_mode;
    logic [3:0]  cfg_th;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        sweep_enable;
    logic [3:0]  sweep_th_min;
    logic [3:0]  sweep_th_max;
    logic [7:0]  sweep_hold;
    logic [2:0]  param_mode;
    logic [3:0]  param_th;
    logic        param_update;
    logic [15:0] frame_count;
    logic        pending;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_run;
    int m_mode, m_th, m_sh_mode, m_sh_th, m_fc, m_frames;
    bit m_pend, m_upd;

    video_mnist_color_sequencer dut (
        .aresetn      (aresetn),
        .aclk         (aclk),
        .mon_tuser    (mon_tuser),
        .mon_tvalid   (mon_tvalid),
        .mon_tready   (mon_tready),
        .cfg_mode     (cfg_mode),
        .cfg_th       (cfg_th),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .sweep_enable (sweep_enable),
        .sweep_th_min (sweep_th_min),
        .sweep_th_max (sweep_th_max),
        .sweep_hold   (sweep_hold),
        .param_mode   (param_mode),
        .param_th     (param_th),
        .param_update (param_update),
        .frame_count  (frame_count),
        .pending      (pending)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sweep_next(int th, int lo, int hi);
        if (lo > hi) return lo;
        if (th == hi || th < lo || th > hi) return lo;
        return th + 1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_mode = 2; m_th = 5; m_sh_mode = 0; m_sh_th = 0;
        m_fc = 0; m_frames = 0; m_pend = 0; m_upd = 0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        bit sof_e;
        bit acc;
        int h;
        sof_e = mon_tvalid && mon_tready && mon_tuser[0];
        acc   = cfg_valid && !m_pend;
        h     = (sweep_hold == 0) ? 1 : int'(sweep_hold);
        m_upd = 0;
        if (sof_e) m_fc = (m_fc + 1) % 65536;
        if (!m_run) begin
            if (acc) begin
                m_mode = cfg_mode; m_th = cfg_th; m_upd = 1;
            end
            if (sof_e) m_run = 1;
        end else begin
            if (sof_e && m_pend) begin
                m_mode = m_sh_mode; m_th = m_sh_th; m_pend = 0; m_frames = 0; m_upd = 1;
            end else if (sof_e && sweep_enable) begin
                m_frames++;
                if (m_frames >= h) begin
                    m_frames = 0;
                    m_th = sweep_next(m_th, sweep_th_min, sweep_th_max);
                    m_upd = 1;
                end
            end
            if (!sweep_enable) m_frames = 0;
            if (acc) begin
                m_sh_mode = cfg_mode; m_sh_th = cfg_th; m_pend = 1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("param_mode", param_mode, m_mode);
        check_eq("param_th", param_th, m_th);
        check_eq("param_update", param_update, m_upd);
        check_eq("frame_count", frame_count, m_fc);
        check_eq("pending", pending, m_pend);
        check_eq("cfg_ready", cfg_ready, !m_pend);
    endtask

    task automatic set_idle();
        mon_tuser = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
        cfg_valid = 1'b0; cfg_mode = '0; cfg_th = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge aclk);
        @(negedge aclk);
        compare_all();
    endtask

    task automatic sof_tick();
        mon_tuser = 1'b1; mon_tvalid = 1'b1; mon_tready = 1'b1;
        tick();
        set_idle();
    endtask

    task automatic cfg_req(input int mode, input int th);
        cfg_valid = 1'b1; cfg_mode = 3'(mode); cfg_th = 4'(th);
    endtask

    // Called just after a falling edge; drops reset between clock edges.
    task automatic async_reset();
        set_idle();
        #3 aresetn = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge aclk);
        aresetn = 1'b1;
        compare_all();
    endtask

    int exp_seq[8] = '{5, 3, 3, 4, 4, 5, 5, 3};

    initial begin
        set_idle();
        sweep_enable = 1'b0; sweep_th_min = 4'd0; sweep_th_max = 4'd15; sweep_hold = 8'd0;
        model_reset();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        compare_all();

        // Host request before the first frame applies on the next edge.
        cfg_req(1, 7);
        tick();
        set_idle();
        check_eq("t1_mode", param_mode, 1);
        check_eq("t1_th", param_th, 7);
        check_eq("t1_update", param_update, 1);
        check_eq("t1_pending", pending, 0);
        tick();
        check_eq("t1_update_drop", param_update, 0);

        // Mid-frame request waits for the next SOF.
        sof_tick();
        tick();
        cfg_req(1, 9);
        tick();
        set_idle();
        check_eq("t2_pending", pending, 1);
        check_eq("t2_ready", cfg_ready, 0);
        check_eq("t2_th_hold", param_th, 7);
        tick();
        sof_tick();
        check_eq("t2_th_apply", param_th, 9);
        check_eq("t2_pending_clr", pending, 0);

        // Request accepted on the SOF edge applies one frame later.
        cfg_req(4, 3);
        sof_tick();
        check_eq("t3_no_change", param_th, 9);
        check_eq("t3_pending", pending, 1);
        tick();
        sof_tick();
        check_eq("t3_th", param_th, 3);
        check_eq("t3_mode", param_mode, 4);

        // Sweep 3..5, hold 2, from th=5.
        async_reset();
        sof_tick();
        sweep_enable = 1'b1; sweep_th_min = 4'd3; sweep_th_max = 4'd5; sweep_hold = 8'd2;
        for (int i = 0; i < 8; i++) begin
            sof_tick();
            check_eq("t4_seq", param_th, exp_seq[i]);
            tick();
        end
        sweep_hold = 8'd0;
        sof_tick();
        check_eq("t4_hold0_a", param_th, 4);
        sof_tick();
        check_eq("t4_hold0_b", param_th, 5);

        // Host update beats the sweep and clears the hold counter.
        sweep_hold = 8'd2;
        sof_tick();
        cfg_req(2, 12);
        tick();
        set_idle();
        sof_tick();
        check_eq("t5_host_th", param_th, 12);
        sof_tick();
        check_eq("t5_hold_clr", param_th, 12);
        sof_tick();
        check_eq("t5_wrap", param_th, 3);
        sweep_th_min = 4'd6; sweep_th_max = 4'd2; sweep_hold = 8'd0;
        sof_tick();
        check_eq("t5_pin_a", param_th, 6);
        sof_tick();
        check_eq("t5_pin_b", param_th, 6);

        // Reset with an update pending discards it.
        sweep_enable = 1'b0;
        cfg_req(3, 1);
        tick();
        set_idle();
        check_eq("t6_pending_set", pending, 1);
        async_reset();
        check_eq("t6_pending", pending, 0);
        check_eq("t6_th", param_th, 5);
        check_eq("t6_mode", param_mode, 2);
        check_eq("t6_fc", frame_count, 0);

        // Random traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 699) == 0) begin
                async_reset();
            end
            if ($urandom_range(0, 99) == 0) sweep_enable = ~sweep_enable;
            if ($urandom_range(0, 149) == 0) begin
                sweep_th_min = 4'($urandom_range(0, 15));
                sweep_th_max = 4'($urandom_range(0, 15));
                sweep_hold   = 8'($urandom_range(0, 4));
            end
            mon_tvalid = ($urandom_range(0, 3) != 0);
            mon_tready = ($urandom_range(0, 3) != 0);
            mon_tuser  = ($urandom_range(0, 5) == 0);
            cfg_valid  = ($urandom_range(0, 9) == 0);
            cfg_mode   = 3'($urandom);
            cfg_th     = 4'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
